// File: rtl/mips16_run_ctrl_if.sv
// Host command channel and instruction-memory write port of the run controller.
// master = host/testbench side, slave = controller side.
interface mips16_run_ctrl_if #(
  parameter int IMEM_AW = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [15:0]        cmd_data;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [15:0]        imem_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips16_run_ctrl.sv
// Run controller for the 16-bit CPU: loads instruction memory, resets/runs/halts/steps the core.
// Optional PC breakpoint under MIPS16_RUN_CTRL_BREAKPOINT_EN; cmd_ready low in CPURST and STEP.
module mips16_run_ctrl #(
  parameter int IMEM_AW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mips16_run_ctrl_if.slave      bus,
  input  logic [15:0]           pc_in,
  output logic                  cpu_rst,
  output logic                  cpu_clk_en,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [15:0]           cyc_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CPURST = 3'd2,
    S_RUN    = 3'd3,
    S_STEP   = 3'd4,
    S_HALT   = 3'd5
  } st_e;

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_HALT  = 3'd4;
  localparam logic [IMEM_AW-1:0] PTR_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};

  st_e                st_q, st_d;
  logic               rst_cnt;
  logic [IMEM_AW-1:0] ptr;
  logic               we_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [15:0]        wdata_q;
  logic               acc;
  logic               load_ptr;
  logic               wr;
  logic               start;
  logic               bp_hit;

  assign bus.cmd_ready  = (st_q != S_CPURST) && (st_q != S_STEP);
  assign acc            = bus.cmd_valid && bus.cmd_ready;
  assign cpu_rst        = (st_q == S_IDLE) || (st_q == S_LOAD) || (st_q == S_CPURST);
  // A breakpoint hit gates the clock in the same cycle so the instruction at that PC never executes.
  assign cpu_clk_en     = ((st_q == S_RUN) && !bp_hit) || (st_q == S_STEP);
  assign halted         = (st_q == S_HALT);
  assign state          = st_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  always_comb begin
    st_d     = st_q;
    load_ptr = 1'b0;
    wr       = 1'b0;
    start    = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (acc && bus.cmd_op == OP_LOAD) begin
          st_d     = S_LOAD;
          load_ptr = 1'b1;
        end else if (acc && bus.cmd_op == OP_RUN) begin
          st_d  = S_CPURST;
          start = 1'b1;
        end
      end
      S_LOAD: begin
        if (acc && bus.cmd_op == OP_LOAD) begin
          wr = 1'b1;
        end else if (acc && bus.cmd_op == OP_RUN) begin
          st_d  = S_CPURST;
          start = 1'b1;
        end else if (acc && bus.cmd_op == OP_HALT) begin
          st_d = S_IDLE;
        end
      end
      S_CPURST: if (rst_cnt) st_d = S_RUN;
      S_RUN:    if (bp_hit || (acc && bus.cmd_op == OP_HALT)) st_d = S_HALT;
      S_STEP:   st_d = S_HALT;
      S_HALT: begin
        if (acc && bus.cmd_op == OP_RUN) begin
          st_d = S_RUN;
        end else if (acc && bus.cmd_op == OP_STEP) begin
          st_d = S_STEP;
        end else if (acc && bus.cmd_op == OP_LOAD) begin
          st_d     = S_LOAD;
          load_ptr = 1'b1;
        end
      end
      default:  st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= S_IDLE;
      rst_cnt   <= 1'b0;
      ptr       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cyc_count <= '0;
    end else begin
      st_q    <= st_d;
      // Second CPURST cycle is marked so the CPU sees exactly two reset cycles.
      rst_cnt <= (st_q == S_CPURST) && !rst_cnt;
      we_q    <= wr;
      if (wr) begin
        addr_q  <= ptr;
        wdata_q <= bus.cmd_data;
        ptr     <= ptr + PTR_ONE;
      end else if (load_ptr) begin
        ptr <= bus.cmd_data[IMEM_AW-1:0];
      end
      if (start)
        cyc_count <= '0;
      else if (cpu_clk_en && cyc_count != 16'hFFFF)
        cyc_count <= cyc_count + 16'd1;
    end
  end

`ifdef MIPS16_RUN_CTRL_BREAKPOINT_EN
  localparam logic [2:0] OP_SETBP = 3'd5;
  logic [15:0] bp_pc;
  logic        bp_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_pc  <= '0;
      bp_vld <= 1'b0;
    end else if (acc && bus.cmd_op == OP_SETBP) begin
      bp_pc  <= bus.cmd_data;
      bp_vld <= 1'b1;
    end
  end

  assign bp_hit = (st_q == S_RUN) && bp_vld && (pc_in == bp_pc);
`else
  logic unused_pc;
  assign unused_pc = ^pc_in;
  assign bp_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_mips16_run_ctrl.sv
// Scoreboard bench for mips16_run_ctrl: a command-level model queues per-cycle status and imem writes,
// a monitor pops and compares them against the DUT.
module tb_mips16_run_ctrl;
  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic        cpu_rst;
  logic        cpu_clk_en;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] cyc_count;

  mips16_run_ctrl_if #(.IMEM_AW(8)) bus ();

  mips16_run_ctrl #(.IMEM_AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .pc_in      (pc_in),
    .cpu_rst    (cpu_rst),
    .cpu_clk_en (cpu_clk_en),
    .state      (state),
    .halted     (halted),
    .cyc_count  (cyc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // status word: state, ready, cpu_rst, clk_en, halted, imem_we, imem_addr, imem_wdata, cyc_count
  logic [47:0] sq[$];
  logic [23:0] wq[$];
  int compared = 0;
  int mismatched = 0;

  // Model state, using the numeric state codes from the requirements.
  int          m_st;
  int          m_rst_left;
  logic [7:0]  m_ptr, m_addr;
  logic [15:0] m_wd, m_cnt, m_bp;
  logic        m_bpv, m_we;

  task automatic model_reset();
    m_st = 0; m_rst_left = 0; m_ptr = 0; m_addr = 0; m_wd = 0;
    m_cnt = 0; m_bp = 0; m_bpv = 0; m_we = 0;
    wq.delete();
  endtask

  task automatic cyc(input logic rn, input logic v, input logic [2:0] op,
                     input logic [15:0] d, input logic [15:0] pc);
    bit acc, hit, en, rdy;
    @(negedge clk);
    reset = rn; bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_data = d; pc_in = pc;
    if (!rn) model_reset();
    rdy = !(m_st == 2 || m_st == 4);
    acc = v && rdy && rn;
    hit = 0;
`ifdef MIPS16_RUN_CTRL_BREAKPOINT_EN
    hit = (m_st == 3) && m_bpv && (pc == m_bp);
`endif
    en = ((m_st == 3) && !hit) || (m_st == 4);
    sq.push_back({3'(m_st), rdy, (m_st <= 2), en, (m_st == 5), m_we, m_addr, m_wd, m_cnt});
    if (rn) begin
      m_we = 0;
      if (en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
`ifdef MIPS16_RUN_CTRL_BREAKPOINT_EN
      if (acc && op == 5) begin m_bp = d; m_bpv = 1; end
`endif
      case (m_st)
        0, 1, 5: begin
          if (acc && op == 1) begin
            if (m_st == 1) begin
              m_we = 1; m_addr = m_ptr; m_wd = d;
              wq.push_back({m_ptr, d});
              m_ptr = m_ptr + 1;
            end else begin
              m_ptr = d[7:0]; m_st = 1;
            end
          end else if (acc && op == 2) begin
            if (m_st == 5) m_st = 3;
            else begin m_st = 2; m_rst_left = 2; m_cnt = 0; end
          end else if (acc && op == 4 && m_st == 1) m_st = 0;
          else if (acc && op == 3 && m_st == 5) m_st = 4;
        end
        2: begin
          m_rst_left = m_rst_left - 1;
          if (m_rst_left == 0) m_st = 3;
        end
        3: if (hit || (acc && op == 4)) m_st = 5;
        default: m_st = 5;
      endcase
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [15:0] d);
    cyc(1'b1, 1'b1, op, d, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
  endtask

  initial begin : monitor
    logic [47:0] e, a;
    logic [23:0] w;
    forever begin
      @(negedge clk);
      #2;
      a = {state, bus.cmd_ready, cpu_rst, cpu_clk_en, halted, bus.imem_we,
           bus.imem_addr, bus.imem_wdata, cyc_count};
      if (sq.size() != 0) begin
        e = sq.pop_front();
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL status t=%0t: got st=%0d rdy=%b rst=%b en=%b hlt=%b we=%b addr=%h wd=%h cnt=%h, exp st=%0d rdy=%b rst=%b en=%b hlt=%b we=%b addr=%h wd=%h cnt=%h",
                   $time, a[47:45], a[44], a[43], a[42], a[41], a[40], a[39:32], a[31:16], a[15:0],
                   e[47:45], e[44], e[43], e[42], e[41], e[40], e[39:32], e[31:16], e[15:0]);
        end
      end
      if (bus.imem_we === 1'b1) begin
        compared++;
        if (wq.size() == 0) begin
          mismatched++;
          $display("FAIL imem_write t=%0t: got unexpected write addr=%h data=%h", $time,
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          w = wq.pop_front();
          if ({bus.imem_addr, bus.imem_wdata} !== w) begin
            mismatched++;
            $display("FAIL imem_write t=%0t: got addr=%h data=%h, exp addr=%h data=%h", $time,
                     bus.imem_addr, bus.imem_wdata, w[23:16], w[15:0]);
          end
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b0; pc_in = 16'h0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_data = 16'h0;
    model_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    idle(2);
    // Load with pointer wrap FE -> FF -> 00
    cmd(3'd1, 16'h00FE);
    cmd(3'd1, 16'h1111);
    cmd(3'd1, 16'h2222);
    cmd(3'd1, 16'h3333);
    idle(1);
    cmd(3'd2, 16'h0);
    idle(12);
    cmd(3'd4, 16'h0);
    idle(3);
    for (int i = 0; i < 3; i++) begin cmd(3'd3, 16'h0); idle(2); end
    cmd(3'd2, 16'h0);
    idle(4);
    cmd(3'd4, 16'h0);
    // Breakpoint at 0x0006 then resume with a counting PC
    cmd(3'd5, 16'h0006);
    cmd(3'd2, 16'h0);
    for (int p = 0; p < 10; p++) cyc(1'b1, 1'b0, 3'd0, 16'h0, (p < 6) ? 16'(p) : 16'h0006);
    cmd(3'd4, 16'h0);
    // Reset during LOAD, right after a write was accepted
    cmd(3'd1, 16'h0010);
    cmd(3'd1, 16'hABCD);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    cyc(1'b0, 1'b1, 3'd1, 16'h5555, 16'h0);
    idle(3);
    // Reset during RUN
    cmd(3'd2, 16'h0);
    idle(6);
    cyc(1'b0, 1'b1, 3'd4, 16'h0, 16'h0);
    idle(2);
    // Randomized command stream with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic rn;
      rn = ($urandom_range(0, 199) != 0);
      cyc(rn, ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom),
          16'($urandom_range(0, 7)));
    end
    idle(3);
    @(negedge clk);
    #3;
    compared++;
    if (sq.size() != 0 || wq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d status and %0d writes outstanding, exp 0 and 0",
               sq.size(), wq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
